// File: rtl/rf_writeback_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl_pkg
// Shared definitions for the register-file writeback controller.
//   REG_AW     : register address width (5 -> 32 integer registers)
//   DATA_W     : register data width (32)
//   NUM_REGS   : number of architectural registers
//   wb_entry_t : one queued long-latency result {rd, data, live}
//                live = 0 means the entry was killed by a younger
//                pipeline write to the same register (or is unoccupied).
// ---------------------------------------------------------------------------
package rf_writeback_ctrl_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              live;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl_if
// Bundles the writeback controller's pipeline, long-latency handshake,
// register-file write port and status signals.
//   master : the environment (pipeline WB stage, long-latency unit,
//            register file and hazard unit)
//   slave  : the writeback controller itself
// Parameter DEPTH sizes fifo_cnt and must match the controller's DEPTH.
// ---------------------------------------------------------------------------
interface rf_writeback_ctrl_if #(
    parameter int DEPTH = 4
);
    import rf_writeback_ctrl_pkg::*;

    logic                    pipe_we;
    logic [REG_AW-1:0]       pipe_rd;
    logic [DATA_W-1:0]       pipe_wd;
    logic                    lu_valid;
    logic                    lu_ready;
    logic [REG_AW-1:0]       lu_rd;
    logic [DATA_W-1:0]       lu_wd;
    logic                    rf_we;
    logic [REG_AW-1:0]       rf_a3;
    logic [DATA_W-1:0]       rf_wd;
    logic [NUM_REGS-1:0]     busy_mask;
    logic                    pipe_stall_req;
    logic [$clog2(DEPTH):0]  fifo_cnt;

    modport master (
        output pipe_we, pipe_rd, pipe_wd, lu_valid, lu_rd, lu_wd,
        input  lu_ready, rf_we, rf_a3, rf_wd, busy_mask, pipe_stall_req, fifo_cnt
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd, lu_valid, lu_rd, lu_wd,
        output lu_ready, rf_we, rf_a3, rf_wd, busy_mask, pipe_stall_req, fifo_cnt
    );

endinterface

// File: rtl/rf_writeback_ctrl_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular buffer of long-latency results waiting for the register-file
// write port. Entries can be killed in place (WAW with a younger pipeline
// write); killed entries still occupy a slot until popped.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   push, push_rd/data   : enqueue request (ignored when full)
//   pop                  : dequeue head (ignored when empty)
//   kill_en, kill_rd     : mark every live entry with rd == kill_rd dead
//   head                 : current head entry
//   empty, full, count   : occupancy, killed entries included
//   live_mask            : bit r set while a live entry targets register r
//   any_live             : at least one live entry is queued
// ---------------------------------------------------------------------------
module wb_fifo
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [REG_AW-1:0]      push_rd,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    input  logic                   kill_en,
    input  logic [REG_AW-1:0]      kill_rd,
    output wb_entry_t              head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [NUM_REGS-1:0]    live_mask,
    output logic                   any_live
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Storage, pointers and occupancy. Kills are applied first, then the
    // popped slot is retired and the pushed slot written; a slot that is
    // pushed this edge was free, so the fresh entry is never hit by the kill.
    // Retiring a popped slot clears its live bit so stale slots never show
    // up in the live mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].live && (mem[i].rd == kill_rd)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (do_pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_ONE;
            end
            if (do_push) begin
                mem[wr_ptr] <= '{rd: push_rd, data: push_data, live: 1'b1};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Live-register mask for the hazard unit; register 0 is never busy.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) begin
                live_mask[mem[i].rd] = 1'b1;
            end
        end
        live_mask[0] = 1'b0;
    end

    assign any_live = |live_mask;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// rf_writeback_ctrl
// Single driver of the integer register file's write port. Each cycle the
// pipeline WB stage has priority; otherwise the head of the long-latency
// result FIFO is written. A starvation counter asks the pipeline for
// bubbles when queued results have waited too long.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : rf_writeback_ctrl_if.slave
//           pipe_we/pipe_rd/pipe_wd       pipeline writeback
//           lu_valid/lu_ready/lu_rd/lu_wd long-latency handshake
//           rf_we/rf_a3/rf_wd             register file WE3/A3/WD3
//           busy_mask, pipe_stall_req, fifo_cnt  status
// Parameters: DEPTH (FIFO entries, power of two, >= 2),
//             STARVE_MAX (pipeline-win cycles before a stall request).
// Build option: define WB_BYPASS_EN to let a long-latency result go straight
// to the write port when the FIFO is empty and the pipeline is not writing.
// ---------------------------------------------------------------------------
module rf_writeback_ctrl
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_ctrl_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    logic                pipe_sel;
    logic                bypass;
    logic                push;
    logic                head_pop;
    logic                head_write;
    wb_entry_t           head;
    logic                empty;
    logic                full;
    logic [CW-1:0]       count;
    logic [NUM_REGS-1:0] live_mask;
    logic                any_live;
    logic [SW-1:0]       starve_cnt;

    assign pipe_sel     = bus.pipe_we && (bus.pipe_rd != '0);
    assign bus.lu_ready = !full && !rst;

`ifdef WB_BYPASS_EN
    assign bypass = empty && !pipe_sel && bus.lu_valid && (bus.lu_rd != '0) && !rst;
`else
    assign bypass = 1'b0;
`endif

    // Results for r0 are accepted but dropped; bypassed results never queue.
    assign push       = bus.lu_valid && bus.lu_ready && (bus.lu_rd != '0) && !bypass;
    // The head leaves whenever the pipeline leaves the port free, even when
    // it was killed; a killed head just burns that cycle without a write.
    assign head_pop   = !pipe_sel && !empty && !rst;
    assign head_write = head_pop && head.live;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (bus.lu_rd),
        .push_data (bus.lu_wd),
        .pop       (head_pop),
        .kill_en   (pipe_sel),
        .kill_rd   (bus.pipe_rd),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .live_mask (live_mask),
        .any_live  (any_live)
    );

    // Write-port mux: pipeline first, then a live FIFO head, then (if built
    // in) the bypassed long-latency result. Nothing is written during reset.
    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_a3 = '0;
        bus.rf_wd = '0;
        if (!rst) begin
            if (pipe_sel) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = bus.pipe_rd;
                bus.rf_wd = bus.pipe_wd;
            end else if (head_write) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = head.rd;
                bus.rf_wd = head.data;
            end else if (bypass) begin
                bus.rf_we = 1'b1;
                bus.rf_a3 = bus.lu_rd;
                bus.rf_wd = bus.lu_wd;
            end
        end
    end

    // Starvation counter: counts cycles the pipeline wins while live results
    // wait, saturating at STARVE_MAX. It restarts once a live result is
    // written or nothing live remains queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!any_live || head_write) begin
            starve_cnt <= '0;
        end else if (pipe_sel && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + STARVE_ONE;
        end
    end

    assign bus.pipe_stall_req = !rst && (starve_cnt >= STARVE_LIM);
    assign bus.busy_mask      = live_mask;
    assign bus.fifo_cnt       = count;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_ctrl
// Directed self-checking bench for rf_writeback_ctrl (DEPTH=4,
// STARVE_MAX=8). Inputs change on the falling edge and outputs are checked
// 1 time unit later; the rising edge commits state.
// ---------------------------------------------------------------------------
module tb_rf_writeback_ctrl;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [31:0] r7_val    = 32'h0;
    int          r7_writes = 0;

    always #5 clk = ~clk;

    rf_writeback_ctrl_if #(.DEPTH(4)) bus ();

    rf_writeback_ctrl #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Tiny register-file model for r7, fed by the write port on commit.
    always @(posedge clk) begin
        if (bus.rf_we === 1'b1 && bus.rf_a3 == 5'd7) begin
            r7_val    <= bus.rf_wd;
            r7_writes <= r7_writes + 1;
        end
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let them settle.
    task automatic applyStimulus(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
        @(negedge clk);
        bus.pipe_we  = pwe;
        bus.pipe_rd  = prd;
        bus.pipe_wd  = pwd;
        bus.lu_valid = lv;
        bus.lu_rd    = lrd;
        bus.lu_wd    = lwd;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        // Reset with traffic present: nothing may be accepted or written.
        rst          = 1'b1;
        bus.pipe_we  = 1'b1;
        bus.pipe_rd  = 5'd4;
        bus.pipe_wd  = 32'hCAFE0004;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd9;
        bus.lu_wd    = 32'h99;
        #2;
        checkOutput("rst_lu_ready", {31'h0, bus.lu_ready}, 32'h0);
        checkOutput("rst_rf_we", {31'h0, bus.rf_we}, 32'h0);
        checkOutput("rst_rf_a3", {27'h0, bus.rf_a3}, 32'h0);
        checkOutput("rst_rf_wd", bus.rf_wd, 32'h0);
        checkOutput("rst_busy", bus.busy_mask, 32'h0);
        checkOutput("rst_stall", {31'h0, bus.pipe_stall_req}, 32'h0);
        repeat (2) @(posedge clk);
        checkOutput("rst_cnt", {29'h0, bus.fifo_cnt}, 32'h0);
        @(negedge clk);
        rst          = 1'b0;
        bus.pipe_we  = 1'b0;
        bus.lu_valid = 1'b0;
        #1;
        checkOutput("rel_lu_ready", {31'h0, bus.lu_ready}, 32'h1);
        checkOutput("rel_cnt", {29'h0, bus.fifo_cnt}, 32'h0);

`ifndef WB_BYPASS_EN
        // Single long-latency result: written exactly one cycle later.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hA5A5A5A5);
        checkOutput("lu5_same_cycle_we", {31'h0, bus.rf_we}, 32'h0);
        idle();
        checkOutput("lu5_we", {31'h0, bus.rf_we}, 32'h1);
        checkOutput("lu5_a3", {27'h0, bus.rf_a3}, 32'd5);
        checkOutput("lu5_wd", bus.rf_wd, 32'hA5A5A5A5);
        checkOutput("lu5_busy", bus.busy_mask, 32'h20);
        checkOutput("lu5_cnt", {29'h0, bus.fifo_cnt}, 32'd1);
        idle();
        checkOutput("lu5_after_we", {31'h0, bus.rf_we}, 32'h0);
        checkOutput("lu5_after_busy", bus.busy_mask, 32'h0);
        checkOutput("lu5_after_cnt", {29'h0, bus.fifo_cnt}, 32'd0);
`else
        // Bypass: empty FIFO, idle pipeline -> written in the same cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h3);
        checkOutput("byp_we", {31'h0, bus.rf_we}, 32'h1);
        checkOutput("byp_a3", {27'h0, bus.rf_a3}, 32'd3);
        checkOutput("byp_wd", bus.rf_wd, 32'h3);
        checkOutput("byp_busy", bus.busy_mask, 32'h0);
        idle();
        checkOutput("byp_cnt", {29'h0, bus.fifo_cnt}, 32'd0);
        checkOutput("byp_after_we", {31'h0, bus.rf_we}, 32'h0);
`endif

        // Fill while the pipeline writes r1 every cycle.
        applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hD0);
        checkOutput("fill_pipe_we", {31'h0, bus.rf_we}, 32'h1);
        checkOutput("fill_pipe_a3", {27'h0, bus.rf_a3}, 32'd1);
        checkOutput("fill_pipe_wd", bus.rf_wd, 32'h100);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + k, (k <= 4), 5'(10 + k), 32'hD0 + k);
            checkOutput($sformatf("fill_cnt_%0d", k), {29'h0, bus.fifo_cnt}, (k < 4) ? k : 4);
            checkOutput($sformatf("fill_ready_%0d", k), {31'h0, bus.lu_ready}, (k < 4) ? 1 : 0);
            checkOutput($sformatf("fill_stall_%0d", k), {31'h0, bus.pipe_stall_req}, (k >= 9) ? 1 : 0);
        end
        checkOutput("fill_busy", bus.busy_mask, 32'h00003C00);

        // Drain in order once the pipeline goes quiet.
        for (int j = 0; j < 4; j++) begin
            idle();
            checkOutput($sformatf("drain_we_%0d", j), {31'h0, bus.rf_we}, 32'h1);
            checkOutput($sformatf("drain_a3_%0d", j), {27'h0, bus.rf_a3}, 10 + j);
            checkOutput($sformatf("drain_wd_%0d", j), bus.rf_wd, 32'hD0 + j);
            checkOutput($sformatf("drain_cnt_%0d", j), {29'h0, bus.fifo_cnt}, 4 - j);
            checkOutput($sformatf("drain_stall_%0d", j), {31'h0, bus.pipe_stall_req}, (j == 0) ? 1 : 0);
        end
        idle();
        checkOutput("drain_done_we", {31'h0, bus.rf_we}, 32'h0);
        checkOutput("drain_done_cnt", {29'h0, bus.fifo_cnt}, 32'd0);
        checkOutput("drain_done_busy", bus.busy_mask, 32'h0);

        // WAW kill: queued r7=0x11 is overtaken by pipeline r7=0x22.
        applyStimulus(1'b1, 5'd2, 32'h55, 1'b1, 5'd7, 32'h11);
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
        checkOutput("kill_busy_before", bus.busy_mask, 32'h80);
        checkOutput("kill_pipe_a3", {27'h0, bus.rf_a3}, 32'd7);
        checkOutput("kill_pipe_wd", bus.rf_wd, 32'h22);
        idle();
        checkOutput("kill_busy_after", bus.busy_mask, 32'h0);
        checkOutput("kill_cnt", {29'h0, bus.fifo_cnt}, 32'd1);
        checkOutput("kill_head_we", {31'h0, bus.rf_we}, 32'h0);
        idle();
        checkOutput("kill_popped_cnt", {29'h0, bus.fifo_cnt}, 32'd0);

        // Same-cycle enqueue with the same rd is younger and survives.
        applyStimulus(1'b1, 5'd8, 32'h33, 1'b1, 5'd8, 32'h44);
        idle();
        checkOutput("young_we", {31'h0, bus.rf_we}, 32'h1);
        checkOutput("young_a3", {27'h0, bus.rf_a3}, 32'd8);
        checkOutput("young_wd", bus.rf_wd, 32'h44);
        checkOutput("young_busy", bus.busy_mask, 32'h100);

        // rd = 0 result is accepted and dropped.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        checkOutput("r0_ready", {31'h0, bus.lu_ready}, 32'h1);
        checkOutput("r0_we_now", {31'h0, bus.rf_we}, 32'h0);
        idle();
        checkOutput("r0_cnt", {29'h0, bus.fifo_cnt}, 32'd0);
        checkOutput("r0_we_next", {31'h0, bus.rf_we}, 32'h0);

        // Reset mid-operation drops queued work and blocks the port.
        applyStimulus(1'b1, 5'd2, 32'h66, 1'b1, 5'd9, 32'h77);
        applyStimulus(1'b1, 5'd3, 32'h88, 1'b0, 5'd0, 32'h0);
        checkOutput("mid_cnt_before", {29'h0, bus.fifo_cnt}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_we", {31'h0, bus.rf_we}, 32'h0);
        checkOutput("mid_rst_cnt", {29'h0, bus.fifo_cnt}, 32'd0);
        checkOutput("mid_rst_busy", bus.busy_mask, 32'h0);
        checkOutput("mid_rst_ready", {31'h0, bus.lu_ready}, 32'h0);
        @(negedge clk);
        rst         = 1'b0;
        bus.pipe_we = 1'b0;
        #1;
        checkOutput("mid_rel_we", {31'h0, bus.rf_we}, 32'h0);
        checkOutput("mid_rel_cnt", {29'h0, bus.fifo_cnt}, 32'd0);

        // The killed r7 result must never have reached the register file.
        idle();
        checkOutput("r7_final", r7_val, 32'h22);
        checkOutput("r7_writes", r7_writes, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
